stage_scheduler: RTL and testbench

Sequences the per-sample effect chain of the guitar processor. On each sample-rate strobe it starts the enabled processing stages one after another, waits for each stage's done handshake, and emits one completion pulse per sample. It sits between the sample-rate strobe generator and the effect stages. It detects sample-budget overruns and hung stages, and reports the cycle cost of the last sample.

---
 rtl/stage_sched_pkg.sv | 16 +
 rtl/stage_watchdog.sv | 39 +++
 rtl/stage_scheduler.sv | 171 +++++++++++++++++
 tb/tb_stage_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_sched_pkg.sv
// Shared types for the per-sample stage scheduler: FSM state encoding and index-width helper.
package stage_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage hang detector: counts WAIT cycles after a start pulse and flags the (TIMEOUT)th one.
// Expiry is combinational from the registered count, so it lines up with the WAIT cycle it refers to.
module stage_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_limit;

  assign at_limit = (cnt_q == W'(TIMEOUT - 1));
  assign expire_o = en_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_scheduler.sv
// Per-sample effect-chain sequencer: starts each enabled stage in turn, waits for its done, pulses sample_valid.
// Tick-to-first-start is 1 cycle; ticks arriving while busy are dropped and flagged as overrun.
module stage_scheduler
  import stage_sched_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int TIMEOUT  = 256,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic [N_STAGES-1:0]           bypass_mask,
  input  logic [N_STAGES-1:0]           stage_done,
  input  logic                          clear_flags,
  output logic [N_STAGES-1:0]           stage_start,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout,
  output logic [idx_w(N_STAGES)-1:0]    fault_stage,
  output logic [CNT_W-1:0]              cycles_used
);

  localparam int IDX_W = idx_w(N_STAGES);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_STAGES-1:0] mask_q, mask_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic [IDX_W-1:0]    fault_q, fault_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    used_q, used_d;

  logic                advance;
  logic                last_stage;
  logic                issue_start;
  logic                wd_en;
  logic                wd_expire;
  logic                timeout_set;
  logic                overrun_set;
  logic [CNT_W-1:0]    cnt_inc;

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (issue_start),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  assign last_stage = (idx_q == IDX_W'(N_STAGES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          mask_d  = bypass_mask;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mask_q[idx_q]) begin
          advance = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      // Done wins over a simultaneous watchdog expiry; either way the chain moves on.
      WAIT: begin
        if (stage_done[idx_q] || wd_expire) begin
          advance = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (advance) begin
      if (last_stage) begin
        state_d = FINISH;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ISSUE;
      end
    end
  end

  always_comb begin
    stage_start = '0;
    issue_start = (state_q == ISSUE) && !mask_q[idx_q];
    if (issue_start) begin
      stage_start[idx_q] = 1'b1;
    end
    sample_valid = (state_q == FINISH);
    busy         = (state_q != IDLE);
    wd_en        = (state_q == WAIT);
  end

  assign timeout_set = (state_q == WAIT) && !stage_done[idx_q] && wd_expire;
  assign overrun_set = sample_tick && (state_q != IDLE);
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    if (clear_flags) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (overrun_set) overrun_d = 1'b1;
    if (timeout_set) timeout_d = 1'b1;

    fault_d = timeout_set ? idx_q : fault_q;

    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (sample_tick) cnt_d = '0;
    end else begin
      cnt_d = cnt_inc;
    end

    // The reported cost includes the FINISH cycle itself.
    used_d = (state_q == FINISH) ? cnt_inc : used_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= '0;
      cnt_q     <= '0;
      used_q    <= '0;
    end else begin
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      used_q    <= used_d;
    end
  end

  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign fault_stage = fault_q;
  assign cycles_used = used_q;

endmodule

// File: tb/tb_stage_scheduler.sv
// Bench for stage_scheduler: table of chain scenarios plus hand sequences for overrun, stray done and mid-chain reset.
module tb_stage_scheduler;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic [N-1:0]  bypass_mask;
  logic [N-1:0]  resp_done = '0;
  logic [N-1:0]  extra_done;
  logic [N-1:0]  stage_done;
  logic          clear_flags;
  logic [N-1:0]  stage_start;
  logic          sample_valid;
  logic          busy;
  logic          overrun;
  logic          timeout;
  logic [1:0]    fault_stage;
  logic [CW-1:0] cycles_used;

  assign stage_done = resp_done | extra_done;

  stage_scheduler #(
    .N_STAGES (N),
    .TIMEOUT  (TO),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .bypass_mask  (bypass_mask),
    .stage_done   (stage_done),
    .clear_flags  (clear_flags),
    .stage_start  (stage_start),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout),
    .fault_stage  (fault_stage),
    .cycles_used  (cycles_used)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scenario record: mask, per-stage done delay (k-th WAIT cycle, 0 = never),
  // expected chain cost, expected start offsets from the tick (0 = no start), flags.
  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][7:0] dly;
    logic [7:0]      cyc;
    logic [3:0][7:0] st;
    logic            to;
    logic [1:0]      fault;
  } vec_t;

  typedef struct {
    int sv_off;
    int cycles;
  } sb_t;

  sb_t sb[$];

  int cyc = 0;
  int tick_cyc = 0;
  int start_cyc[4] = '{-1, -1, -1, -1};
  int dly[4] = '{0, 0, 0, 0};
  int rem[4] = '{0, 0, 0, 0};
  bit cu_chk = 0;
  int cu_exp = 0;

  always @(posedge clk) cyc++;

  // Stage model: raise done in the dly-th cycle after the start pulse.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        rem[i] = 0;
        resp_done[i] = 1'b0;
      end else begin
        if (rem[i] == 1) begin
          resp_done[i] = 1'b1;
          rem[i] = 0;
        end else begin
          resp_done[i] = 1'b0;
          if (rem[i] > 1) rem[i]--;
        end
        if (stage_start[i]) rem[i] = dly[i];
      end
    end
  end

  // Output monitor: pops the scoreboard on each sample_valid.
  always @(negedge clk) begin
    sb_t e;
    if (cu_chk) begin
      check("cycles_used", int'(cycles_used), cu_exp);
      cu_chk = 0;
    end
    if (stage_start != '0) begin
      check("start_onehot", int'($onehot(stage_start)), 1);
      for (int i = 0; i < N; i++) if (stage_start[i]) start_cyc[i] = cyc;
    end
    if (sample_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_valid: unexpected pulse at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        check("sample_valid_offset", cyc - tick_cyc, e.sv_off);
        cu_exp = e.cycles;
        cu_chk = 1;
      end
    end
  end

  task automatic fire_tick(input int exp_cycles);
    @(negedge clk);
    sample_tick = 1'b1;
    tick_cyc = cyc;
    sb.push_back('{sv_off: exp_cycles, cycles: exp_cycles});
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || cu_chk) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL %s: chain completion got none within 80 cycles, required sample_valid", name);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] m, input int d0, input int d1, input int d2,
                              input int d3, input int c, input int s0, input int s1,
                              input int s2, input int s3, input bit t, input int f);
    vec_t v;
    v.mask = m;
    v.dly[0] = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2); v.dly[3] = 8'(d3);
    v.cyc = 8'(c);
    v.st[0] = 8'(s0); v.st[1] = 8'(s1); v.st[2] = 8'(s2); v.st[3] = 8'(s3);
    v.to = t;
    v.fault = 2'(f);
    return v;
  endfunction

  vec_t vecs[8];
  int   exp_fault = 0;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation got no end by 100us, required completion");
    $fatal(1, "tb_stage_scheduler stalled");
  end

  initial begin
    vecs[0] = mk(4'b1111, 0, 0, 0, 0,  5, 0,  0,  0,  0, 1'b0, 0);
    vecs[1] = mk(4'b0000, 2, 2, 2, 2, 13, 1,  4,  7, 10, 1'b0, 0);
    vecs[2] = mk(4'b0000, 1, 1, 1, 1,  9, 1,  3,  5,  7, 1'b0, 0);
    vecs[3] = mk(4'b0101, 0, 3, 0, 3, 11, 0,  2,  0,  7, 1'b0, 0);
    vecs[4] = mk(4'b0000, 8, 1, 1, 1, 16, 1, 10, 12, 14, 1'b0, 0);
    vecs[5] = mk(4'b0000, 9, 1, 1, 1, 16, 1, 10, 12, 14, 1'b1, 0);
    vecs[6] = mk(4'b0000, 1, 1, 0, 1, 16, 1,  3,  5, 14, 1'b1, 2);
    vecs[7] = mk(4'b1000, 1, 2, 3, 0, 11, 1,  3,  6,  0, 1'b0, 0);

    rst = 1'b1;
    sample_tick = 1'b0;
    clear_flags = 1'b0;
    bypass_mask = '0;
    extra_done = '0;
    repeat (3) @(negedge clk);
    check("reset_stage_start", int'(stage_start), 0);
    check("reset_sample_valid", int'(sample_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_fault_stage", int'(fault_stage), 0);
    check("reset_cycles_used", int'(cycles_used), 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      bypass_mask = vecs[v].mask;
      for (int i = 0; i < N; i++) dly[i] = int'(vecs[v].dly[i]);
      fire_tick(int'(vecs[v].cyc));
      bypass_mask = ~vecs[v].mask;
      wait_done($sformatf("vec%0d", v));
      for (int i = 0; i < N; i++) begin
        if (vecs[v].st[i] == 8'd0)
          check($sformatf("vec%0d_no_start%0d", v, i), int'(start_cyc[i] <= tick_cyc), 1);
        else
          check($sformatf("vec%0d_start%0d", v, i), start_cyc[i] - tick_cyc, int'(vecs[v].st[i]));
      end
      check($sformatf("vec%0d_timeout", v), int'(timeout), int'(vecs[v].to));
      if (vecs[v].to) exp_fault = int'(vecs[v].fault);
      check($sformatf("vec%0d_fault_stage", v), int'(fault_stage), exp_fault);
      check($sformatf("vec%0d_overrun", v), int'(overrun), 0);
      pulse_clear();
      check($sformatf("vec%0d_timeout_cleared", v), int'(timeout), 0);
    end

    // Overrun: a tick 5 cycles into the chain, coinciding with clear_flags.
    bypass_mask = '0;
    for (int i = 0; i < N; i++) dly[i] = 2;
    fire_tick(13);
    repeat (4) @(negedge clk);
    sample_tick = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    clear_flags = 1'b0;
    check("overrun_set_wins", int'(overrun), 1);
    check("overrun_chain_busy", int'(busy), 1);
    wait_done("overrun_chain");
    check("overrun_sticky", int'(overrun), 1);
    pulse_clear();
    check("overrun_cleared", int'(overrun), 0);
    repeat (20) @(negedge clk);
    check("overrun_no_second_chain", int'(busy), 0);

    // Stray done for stage 3 while stage 1 is pending.
    dly[0] = 1; dly[1] = 0; dly[2] = 1; dly[3] = 1;
    fire_tick(12);
    repeat (4) @(negedge clk);
    extra_done = 4'b1000;
    @(negedge clk);
    extra_done = 4'b0000;
    check("stray_done_no_start", int'(stage_start), 0);
    check("stray_done_busy", int'(busy), 1);
    @(negedge clk);
    extra_done = 4'b0010;
    @(negedge clk);
    extra_done = 4'b0000;
    check("done1_starts_stage2", int'(stage_start), 4);
    wait_done("stray_chain");
    check("stray_start1", start_cyc[1] - tick_cyc, 3);
    check("stray_timeout", int'(timeout), 0);

    // Reset while waiting on stage 1, then restart from stage 0.
    fire_tick(12);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_stage_start", int'(stage_start), 0);
    check("midrst_sample_valid", int'(sample_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_timeout", int'(timeout), 0);
    check("midrst_fault_stage", int'(fault_stage), 0);
    check("midrst_cycles_used", int'(cycles_used), 0);
    repeat (3) @(negedge clk);
    check("midrst_idle_no_valid", int'(sample_valid), 0);
    for (int i = 0; i < N; i++) dly[i] = 1;
    fire_tick(9);
    wait_done("restart_chain");
    check("restart_start0", start_cyc[0] - tick_cyc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
